// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data memory responder.
// Holds the host/clear FSM state encoding and the default geometry.
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam logic [15:0] WR_COUNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ACCESS_ACK = 2'd1,
    CLEAR      = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Reset-free word array: two combinational read ports and two write ports.
// The primary write port wins when both ports target the same address in a cycle.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              pri_we,
  input  logic [ADDR_W-1:0] pri_addr,
  input  logic [DATA_W-1:0] pri_wdata,
  input  logic              sec_we,
  input  logic [ADDR_W-1:0] sec_addr,
  input  logic [DATA_W-1:0] sec_wdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign cpu_rdata  = mem[cpu_addr];
  assign host_rdata = mem[host_addr];

  // Primary is applied last so it overrides a same-address secondary write.
  always_ff @(posedge clock) begin
    if (sec_we) mem[sec_addr] <= sec_wdata;
    if (pri_we) mem[pri_addr] <= pri_wdata;
  end

endmodule

// File: rtl/cpu_data_mem.sv
// CPU MEM-stage data memory: zero-latency loads, clocked stores, plus a
// handshaked host port for preload/dump and a sequenced whole-memory clear.
module cpu_data_mem
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  input  logic              h_clr,
  output logic              h_ack,
  output logic [DATA_W-1:0] h_rdata,
  output logic              mem_busy,
  output logic [15:0]       wr_count,
  output state_t            fsm_state
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] clr_ptr;
  logic              cpu_wr;
  logic              host_go;
  logic              host_wr;
  logic              clr_start;
  logic              clr_step;
  logic              clr_last;
  logic [DATA_W-1:0] host_rd;

  // A CPU store is the only source of host contention.
  assign cpu_wr    = enable & d_we;
  assign clr_last  = (clr_ptr == ADDR_W'(DEPTH - 1));
  assign host_wr   = host_go & h_we;
  assign fsm_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    host_go    = 1'b0;
    clr_start  = 1'b0;
    clr_step   = 1'b0;
    unique case (state)
      IDLE: begin
        if (h_clr) begin
          clr_start  = 1'b1;
          next_state = CLEAR;
        end else if (h_req && !cpu_wr) begin
          host_go    = 1'b1;
          next_state = ACCESS_ACK;
        end
      end
      ACCESS_ACK: begin
        if (!h_req) next_state = IDLE;
      end
      CLEAR: begin
        clr_step = 1'b1;
        if (clr_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_ack    <= 1'b0;
      h_rdata  <= '0;
      mem_busy <= 1'b0;
      clr_ptr  <= '0;
      wr_count <= '0;
    end else begin
      h_ack <= host_go;
      if (host_go && !h_we) h_rdata <= host_rd;
      if (clr_start) begin
        mem_busy <= 1'b1;
        clr_ptr  <= '0;
      end else if (clr_step) begin
        if (clr_last) begin
          mem_busy <= 1'b0;
          clr_ptr  <= '0;
        end else begin
          clr_ptr <= clr_ptr + 1'b1;
        end
      end
      if (cpu_wr && wr_count != WR_COUNT_MAX) wr_count <= wr_count + 16'd1;
    end
  end

  // CPU store takes the primary port; clear and host share the secondary
  // (they are never active in the same cycle).
  dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clock     (clock),
    .cpu_addr  (d_addr),
    .cpu_rdata (d_datain),
    .host_addr (h_addr),
    .host_rdata(host_rd),
    .pri_we    (cpu_wr),
    .pri_addr  (d_addr),
    .pri_wdata (d_dataout),
    .sec_we    (clr_step | host_wr),
    .sec_addr  (clr_step ? clr_ptr : h_addr),
    .sec_wdata (clr_step ? '0 : h_wdata)
  );

endmodule

// File: tb/tb_cpu_data_mem.sv
// Directed bench for cpu_data_mem: scoreboard queue of expected values fed from
// a reference memory model, compared with immediate assertions.
module tb_cpu_data_mem;
  import cpu_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  d_addr;
  logic [15:0] d_dataout;
  logic        d_we;
  logic [15:0] d_datain;
  logic        h_req;
  logic        h_we;
  logic [7:0]  h_addr;
  logic [15:0] h_wdata;
  logic        h_clr;
  logic        h_ack;
  logic [15:0] h_rdata;
  logic        mem_busy;
  logic [15:0] wr_count;
  state_t      fsm_state;

  logic [15:0] exp_q[$];
  logic [15:0] model [256];
  int          checks = 0;
  int          errors = 0;

  cpu_data_mem dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .d_addr   (d_addr),
    .d_dataout(d_dataout),
    .d_we     (d_we),
    .d_datain (d_datain),
    .h_req    (h_req),
    .h_we     (h_we),
    .h_addr   (h_addr),
    .h_wdata  (h_wdata),
    .h_clr    (h_clr),
    .h_ack    (h_ack),
    .h_rdata  (h_rdata),
    .mem_busy (mem_busy),
    .wr_count (wr_count),
    .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs);
    logic [15:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  task automatic cpu_read(input string tag, input logic [7:0] addr);
    d_addr = addr;
    #1;
    exp_q.push_back(model[addr]);
    check(tag, d_datain);
  endtask

  // Full host handshake: raise h_req, wait for h_ack, drop h_req, settle to IDLE.
  task automatic host_access(input logic we, input logic [7:0] addr, input logic [15:0] wdata);
    int lat;
    h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = wdata;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!h_ack && lat < 20);
    exp_q.push_back(16'd1);
    check("ack_latency", 16'(lat));
    if (!we) begin
      exp_q.push_back(model[addr]);
      check("host_rdata", h_rdata);
    end else begin
      model[addr] = wdata;
    end
    h_req = 1'b0;
    tick();
    exp_q.push_back(16'd0);
    check("ack_single_pulse", {15'd0, h_ack});
  endtask

  initial begin
    int n;
    int busy_cycles;
    reset = 1'b0; enable = 1'b0; d_addr = '0; d_dataout = '0; d_we = 1'b0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0; h_clr = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    exp_q.push_back(16'd0); check("por_h_ack", {15'd0, h_ack});
    exp_q.push_back(16'd0); check("por_mem_busy", {15'd0, mem_busy});
    exp_q.push_back(16'd0); check("por_wr_count", wr_count);
    exp_q.push_back(16'(IDLE)); check("por_state", 16'(fsm_state));

    // CPU store/load with read-before-write
    host_access(1'b1, 8'h05, 16'h0A0A);
    enable = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_dataout = 16'h2221;
    #1;
    exp_q.push_back(model[8'h05]); check("rbw_old_value", d_datain);
    tick();
    d_we = 1'b0;
    model[8'h05] = 16'h2221;
    cpu_read("load_after_store", 8'h05);
    exp_q.push_back(16'd1); check("wr_count_one", wr_count);

    // host write then read
    host_access(1'b1, 8'h10, 16'hBEEF);
    host_access(1'b0, 8'h10, 16'h0000);
    exp_q.push_back(16'hBEEF); check("h_rdata_held", h_rdata);
    cpu_read("cpu_sees_host_write", 8'h10);

    // mid-cycle async reset; memory contents survive
    #2 reset = 1'b0;
    #1;
    exp_q.push_back(16'd0); check("rst_h_ack", {15'd0, h_ack});
    exp_q.push_back(16'd0); check("rst_h_rdata", h_rdata);
    exp_q.push_back(16'd0); check("rst_mem_busy", {15'd0, mem_busy});
    exp_q.push_back(16'd0); check("rst_wr_count", wr_count);
    tick();
    reset = 1'b1;
    tick();
    cpu_read("mem_kept_05", 8'h05);
    cpu_read("mem_kept_10", 8'h10);

    // contention: CPU store holds off the host for three cycles
    enable = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_dataout = 16'h1111;
    h_req = 1'b1; h_we = 1'b1; h_addr = 8'h20; h_wdata = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_q.push_back(16'd0); check("stall_no_ack", {15'd0, h_ack});
    end
    d_we = 1'b0;
    model[8'h20] = 16'h1111;
    cpu_read("cpu_store_during_stall", 8'h20);
    tick();
    exp_q.push_back(16'd1); check("ack_after_conflict", {15'd0, h_ack});
    model[8'h20] = 16'h2222;
    h_req = 1'b0;
    tick();
    cpu_read("host_wins_later", 8'h20);
    exp_q.push_back(16'd3); check("wr_count_three", wr_count);

    // whole-memory clear with a CPU store racing the sweep at 0x80
    host_access(1'b1, 8'h00, 16'h1234);
    host_access(1'b1, 8'hFF, 16'h5678);
    cpu_read("preload_ff", 8'hFF);
    h_clr = 1'b1;
    tick();
    h_clr = 1'b0;
    exp_q.push_back(16'd1); check("busy_after_clr", {15'd0, mem_busy});
    for (int a = 0; a < 256; a++) model[a] = 16'h0000;
    n = 0;
    busy_cycles = 0;
    while (mem_busy && n < 400) begin
      if (n == 128) begin
        d_we = 1'b1; d_addr = 8'h80; d_dataout = 16'hABCD;
      end else begin
        d_we = 1'b0;
      end
      tick();
      n++;
      busy_cycles++;
    end
    d_we = 1'b0;
    model[8'h80] = 16'hABCD;
    exp_q.push_back(16'd256); check("busy_cycles", 16'(busy_cycles));
    exp_q.push_back(16'(IDLE)); check("state_after_clear", 16'(fsm_state));
    cpu_read("cleared_00", 8'h00);
    cpu_read("cleared_ff", 8'hFF);
    cpu_read("cpu_wins_clear_80", 8'h80);
    exp_q.push_back(16'd4); check("wr_count_four", wr_count);

    // reset in the middle of a clear sweep
    host_access(1'b1, 8'h40, 16'h5555);
    host_access(1'b1, 8'h3F, 16'h6666);
    h_clr = 1'b1;
    tick();
    h_clr = 1'b0;
    n = 0;
    while (n < 64) begin
      tick();
      n++;
    end
    reset = 1'b0;
    #1;
    exp_q.push_back(16'd0); check("abort_mem_busy", {15'd0, mem_busy});
    exp_q.push_back(16'(IDLE)); check("abort_state", 16'(fsm_state));
    tick();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 64; a++) model[a] = 16'h0000;
    cpu_read("abort_cleared_3f", 8'h3F);
    cpu_read("abort_kept_40", 8'h40);
    cpu_read("abort_kept_41", 8'h41);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
